// File: rtl/repeat_n.sv
// Sample/packet repeater for the interpolating RFNoC block: each input sample, or each
// buffered packet, is emitted n times on a 32-bit AXI-stream.
//
// state  | meaning
// IDLE   | waiting for the first word of a sample or packet
// REPEAT | sample mode, output register holds one sample being copied
// FILL   | vector mode, writing the packet into the buffer
// PLAY   | vector mode, replaying buffer words 0..last_addr n times
module repeat_n #(
  parameter int WIDTH      = 32,
  parameter int MAX_N      = 65535,
  parameter int BUF_ADDR_W = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vector_mode,
  input  logic [15:0]      n,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REPEAT = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_PLAY   = 2'd3;
  localparam logic [BUF_ADDR_W-1:0] ADDR_MAX = '1;

  logic [1:0]            state;
  logic [15:0]           n_eff, n_lat, copy;
  logic                  held_last;
  logic [BUF_ADDR_W-1:0] wr_addr, last_addr, rd_addr;
  logic                  full, issue_done;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_vld, rd_last, rd_final, o_final;
  logic                  in_rdy, i_hs, o_hs, adv, last_copy, fill_acc, wr_en;
  logic [WIDTH-1:0]      mem [2**BUF_ADDR_W];

  always_comb begin
    n_eff = n;
    if (n == 16'd0) n_eff = 16'd1;
    else if (32'(n) > MAX_N) n_eff = 16'(MAX_N);
  end

  assign o_hs      = o_tvalid && o_tready;
  assign adv       = !o_tvalid || o_tready;
  assign last_copy = (copy == n_lat - 16'd1);

  // In REPEAT a new sample is taken only while the final copy leaves, so nothing is lost
  always_comb begin
    in_rdy = 1'b0;
    if (reset_n) begin
      case (state)
        S_IDLE:   in_rdy = 1'b1;
        S_REPEAT: in_rdy = o_tready && last_copy && !vector_mode;
        S_FILL:   in_rdy = 1'b1;
        default:  in_rdy = 1'b0;
      endcase
    end
  end

  assign i_tready = in_rdy;
  assign i_hs     = i_tvalid && in_rdy;
  assign fill_acc = i_hs && ((state == S_IDLE && vector_mode) || state == S_FILL);
  assign wr_en    = fill_acc && !full;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= i_tdata;
  end

  always_ff @(posedge clk) begin
    if (adv) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      o_tvalid   <= 1'b0;
      o_tlast    <= 1'b0;
      o_tdata    <= '0;
      overflow   <= 1'b0;
      n_lat      <= 16'd1;
      copy       <= '0;
      held_last  <= 1'b0;
      wr_addr    <= '0;
      last_addr  <= '0;
      rd_addr    <= '0;
      full       <= 1'b0;
      issue_done <= 1'b0;
      rd_vld     <= 1'b0;
      rd_last    <= 1'b0;
      rd_final   <= 1'b0;
      o_final    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_hs) begin
            n_lat <= n_eff;
            copy  <= '0;
            if (vector_mode) begin
              state <= i_tlast ? S_PLAY : S_FILL;
            end else begin
              o_tvalid  <= 1'b1;
              o_tdata   <= i_tdata;
              o_tlast   <= i_tlast && (n_eff == 16'd1);
              held_last <= i_tlast;
              state     <= S_REPEAT;
            end
          end
        end
        S_REPEAT: begin
          if (o_hs) begin
            if (!last_copy) begin
              copy    <= copy + 16'd1;
              o_tlast <= held_last && (copy + 16'd1 == n_lat - 16'd1);
            end else if (i_hs) begin
              n_lat     <= n_eff;
              copy      <= '0;
              o_tdata   <= i_tdata;
              o_tlast   <= i_tlast && (n_eff == 16'd1);
              held_last <= i_tlast;
            end else begin
              o_tvalid <= 1'b0;
              o_tlast  <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        S_FILL: begin
          if (i_hs && i_tlast) state <= S_PLAY;
        end
        default: begin
          // Two-stage pipe: buffer read register, then output register; both move on adv
          if (adv) begin
            o_tvalid <= rd_vld;
            o_tdata  <= rd_data;
            o_tlast  <= rd_vld && rd_last;
            o_final  <= rd_final;
            rd_vld   <= !issue_done;
            rd_last  <= (rd_addr == last_addr);
            rd_final <= (rd_addr == last_addr) && last_copy;
            if (!issue_done) begin
              if (rd_addr == last_addr) begin
                rd_addr <= '0;
                if (last_copy) issue_done <= 1'b1;
                else copy <= copy + 16'd1;
              end else begin
                rd_addr <= rd_addr + 1'b1;
              end
            end
          end
          if (o_hs && o_tlast && o_final) begin
            state    <= S_IDLE;
            rd_vld   <= 1'b0;
            o_final  <= 1'b0;
          end
        end
      endcase

      // Buffer fill; once the last address is used, the rest of the packet is dropped
      if (fill_acc) begin
        if (full) begin
          overflow <= 1'b1;
        end else if (i_tlast) begin
          last_addr <= wr_addr;
        end else if (wr_addr == ADDR_MAX) begin
          full      <= 1'b1;
          last_addr <= ADDR_MAX;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
        if (i_tlast) begin
          wr_addr    <= '0;
          full       <= 1'b0;
          rd_addr    <= '0;
          copy       <= '0;
          issue_done <= 1'b0;
          rd_vld     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_repeat_n.sv
// Scoreboard bench for repeat_n: directed packets push expected words, a monitor pops and
// compares every output handshake and checks that stalled outputs stay put.
module tb_repeat_n;

  logic        clk = 1'b0;
  logic        reset_n, vector_mode, i_tlast, i_tvalid, i_tready;
  logic        o_tlast, o_tvalid, o_tready, overflow;
  logic [15:0] n;
  logic [31:0] i_tdata, o_tdata;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int          cyc    = 0;
  bit          rand_rdy = 1'b0;
  logic [32:0] exp_q[$];
  logic [31:0] pkt[0:2049];

  repeat_n #(.WIDTH(32), .MAX_N(65535), .BUF_ADDR_W(11)) dut (
    .clk(clk), .reset_n(reset_n), .vector_mode(vector_mode), .n(n),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic finish_tb();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  endtask

  // Monitor: compare each output handshake and verify held data during stalls
  logic        st_pend = 1'b0;
  logic [32:0] st_val  = '0;
  always @(negedge clk) begin
    logic [32:0] e;
    if (st_pend) check("hold_stable", {o_tvalid, o_tlast, o_tdata}, {1'b1, st_val});
    st_pend = o_tvalid && !o_tready && reset_n;
    st_val  = {o_tlast, o_tdata};
    if (o_tvalid && o_tready && reset_n) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("out_word", {o_tlast, o_tdata}, e);
      end
    end
  end

  task automatic push_pkt(input bit vm, input int nn, input int len);
    int ne;
    logic l;
    ne = (nn == 0) ? 1 : nn;
    if (vm) begin
      for (int c = 0; c < ne; c++)
        for (int i = 0; i < len; i++) begin
          l = (i == len - 1);
          exp_q.push_back({l, pkt[i]});
        end
    end else begin
      for (int i = 0; i < len; i++)
        for (int c = 0; c < ne; c++) begin
          l = (i == len - 1) && (c == ne - 1);
          exp_q.push_back({l, pkt[i]});
        end
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int waited;
    waited = 0;
    i_tdata = d; i_tlast = last; i_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (i_tready) break;
      waited++;
      if (waited > 20000) begin
        check("send_timeout", 64'(i_tready), 64'd1);
        finish_tb();
      end
    end
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input bit vm, input int nn, input int len);
    vector_mode = vm;
    n = 16'(nn);
    push_pkt(vm, nn, len);
    for (int i = 0; i < len; i++) send(pkt[i], i == len - 1);
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !(exp_q.size() == 0 && !o_tvalid && i_tready)) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(exp_q.size() == 0 && !o_tvalid && i_tready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    check("watchdog", 64'(exp_q.size() == 0 && i_tready), 64'd2);
    finish_tb();
  end

  initial begin
    int t0, len;
    bit vm;
    reset_n = 1'b0; vector_mode = 1'b0; n = 16'd1;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_tlast", 64'(o_tlast), 64'd0);
    check("rst_tdata", 64'(o_tdata), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_tready", 64'(i_tready), 64'd0);
    reset_n = 1'b1;
    #1;
    check("rst_release_tready", 64'(i_tready), 64'd1);
    @(posedge clk);
    #1;

    // Sample mode, n=3, {A,B}: A A A B B B, tlast on 6th, 1-cycle latency
    pkt[0] = 32'hA0A0_0001; pkt[1] = 32'hB0B0_0002;
    vector_mode = 1'b0; n = 16'd3;
    push_pkt(1'b0, 3, 2);
    send(pkt[0], 1'b0);
    check("lat_tvalid", 64'(o_tvalid), 64'd1);
    check("lat_tdata", 64'(o_tdata), 64'hA0A0_0001);
    check("lat_tlast", 64'(o_tlast), 64'd0);
    send(pkt[1], 1'b1);
    drain("t1_drain", 50);

    // n=0 and n=1: pass-through at 1 word/clk
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) pkt[i] = 32'h100 + 32'(i) + 32'(k * 16);
      vector_mode = 1'b0; n = 16'(k);
      push_pkt(1'b0, k, 8);
      t0 = cyc;
      for (int i = 0; i < 8; i++) send(pkt[i], i == 7);
      check("passthru_cycles", 64'(cyc - t0), 64'd8);
      drain("t2_drain", 50);
    end

    // Vector mode, n=2, {1,2,3,4}
    for (int i = 0; i < 4; i++) pkt[i] = 32'(i + 1);
    send_pkt(1'b1, 2, 4);
    check("play_tready", 64'(i_tready), 64'd0);
    check("vec_lat0", 64'(o_tvalid), 64'd0);
    @(posedge clk); #1;
    check("vec_lat1", 64'(o_tvalid), 64'd0);
    @(posedge clk); #1;
    check("vec_lat2", 64'(o_tvalid), 64'd1);
    check("vec_first", 64'(o_tdata), 64'd1);
    check("play_tready2", 64'(i_tready), 64'd0);
    drain("t3_drain", 100);

    // Random 50% backpressure, both modes, n=5, 100 packets
    rand_rdy = 1'b1;
    for (int p = 0; p < 100; p++) begin
      vm  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) pkt[i] = $urandom;
      send_pkt(vm, 5, len);
    end
    drain("rand_drain", 5000);
    rand_rdy = 1'b0;
    check("no_overflow_yet", 64'(overflow), 64'd0);

    // Vector overflow: 2050 words in, 2048 replayed twice
    for (int i = 0; i < 2050; i++) pkt[i] = 32'(i);
    vector_mode = 1'b1; n = 16'd2;
    push_pkt(1'b1, 2, 2048);
    for (int i = 0; i < 2050; i++) send(pkt[i], i == 2049);
    drain("ovf_drain", 10000);
    check("ovf_set", 64'(overflow), 64'd1);
    pkt[0] = 32'h7; pkt[1] = 32'h8;
    send_pkt(1'b1, 1, 2);
    drain("post_ovf_drain", 50);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Reset in the middle of PLAY
    for (int i = 0; i < 4; i++) pkt[i] = 32'(10 + i);
    send_pkt(1'b1, 3, 4);
    repeat (4) begin @(posedge clk); #1; end
    check("midplay_active", 64'(o_tvalid), 64'd1);
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("rst2_tvalid", 64'(o_tvalid), 64'd0);
    check("rst2_tlast", 64'(o_tlast), 64'd0);
    check("rst2_overflow", 64'(overflow), 64'd0);
    check("rst2_tready", 64'(i_tready), 64'd0);
    reset_n = 1'b1;
    #1;
    check("rst2_release_tready", 64'(i_tready), 64'd1);
    pkt[0] = 32'h55; pkt[1] = 32'h66;
    send_pkt(1'b1, 1, 2);
    drain("rst2_drain", 50);

    finish_tb();
  end

endmodule
